// File: rtl/ppu_pkg.sv
// Shared PPU types and framebuffer geometry for the background pixel writer.
package ppu_pkg;

    typedef enum logic [1:0] {
        H_BLANK = 2'd0,
        V_BLANK = 2'd1,
        SCAN    = 2'd2,
        DRAW    = 2'd3
    } PPU_STATES_t;

    localparam int unsigned FB_WIDTH          = 160;
    localparam int unsigned FB_HEIGHT         = 144;
    localparam int unsigned FB_BYTES_PER_LINE = 40;
    localparam int unsigned FB_BYTES          = 5760;
    localparam int unsigned FB_ADDR_W         = 13;
    localparam int unsigned FB_DATA_W         = 8;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] data;
    } fb_entry_t;

    // BGP lookup: colour for index n lives in bgp[2n+1:2n].
    function automatic logic [1:0] bgp_map(input logic [1:0] idx, input logic [7:0] bgp);
        logic [1:0] c;
        case (idx)
            2'd0:    c = bgp[1:0];
            2'd1:    c = bgp[3:2];
            2'd2:    c = bgp[5:4];
            default: c = bgp[7:6];
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fb_byte_fifo.sv
// Small synchronous FIFO of {addr, data} framebuffer writes; push while full
// is accepted only when a pop frees the slot in the same cycle.
module fb_byte_fifo
    import ppu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  fb_entry_t push_entry,
    input  logic      pop,
    output fb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    fb_entry_t        mem_q [DEPTH];
    fb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && !empty_q;
        do_push  = push && (!full_q || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/ppu_fb_writer.sv
// Packs the PPU background pixel stream four-per-byte into the 2 bpp framebuffer.
// Define FB_PALETTE_EN to map pixels through BGP; otherwise raw indices are stored.
module ppu_fb_writer
    import ppu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [12:0] FB_BASE    = 13'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  PX_OUT,
    input  logic        PX_valid,
    input  logic [1:0]  PPU_MODE,
    input  logic [7:0]  BGP,
    output logic [12:0] fb_addr,
    output logic [7:0]  fb_data,
    output logic        fb_wr,
    input  logic        fb_ready,
    output logic        frame_done,
    output logic        overflow
);

    logic [7:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [1:0]  phase_q, phase_d;
    logic [5:0]  pack_q, pack_d;
    PPU_STATES_t prev_mode_q, prev_mode_d;
    logic        frame_done_q, frame_done_d;
    logic        overflow_q, overflow_d;

    PPU_STATES_t mode;
    logic        accept, line_end, frame_end;
    logic [1:0]  colour;
    logic [12:0] line_addr;
    logic        push, pop;
    fb_entry_t   push_entry, head;
    logic        fifo_full, fifo_empty;

`ifdef FB_PALETTE_EN
    assign colour = bgp_map(PX_OUT, BGP);
`else
    logic unused_bgp;
    assign colour     = PX_OUT;
    assign unused_bgp = ^BGP;
`endif

    always_comb begin
        mode      = PPU_STATES_t'(PPU_MODE);
        accept    = PX_valid && (mode == DRAW) && (x_q < 8'(FB_WIDTH));
        line_end  = (prev_mode_q == DRAW) && (mode == H_BLANK);
        frame_end = (mode == V_BLANK) && (prev_mode_q != V_BLANK);
        line_addr = FB_BASE + 13'(y_q) * 13'(FB_BYTES_PER_LINE) + 13'(x_q >> 2);

        x_d          = x_q;
        y_d          = y_q;
        phase_d      = phase_q;
        pack_d       = pack_q;
        push         = 1'b0;
        push_entry   = '0;
        prev_mode_d  = mode;
        frame_done_d = frame_end;

        if (frame_end) begin
            // Partial group at frame end is discarded, not flushed.
            x_d     = '0;
            y_d     = '0;
            phase_d = '0;
            pack_d  = '0;
        end else if (line_end) begin
            if (phase_q != 2'd0) begin
                push            = 1'b1;
                push_entry.addr = line_addr;
                case (phase_q)
                    2'd1:    push_entry.data = {pack_q[1:0], 6'b0};
                    2'd2:    push_entry.data = {pack_q[3:0], 4'b0};
                    default: push_entry.data = {pack_q, 2'b0};
                endcase
            end
            x_d     = '0;
            phase_d = '0;
            pack_d  = '0;
            y_d     = (y_q == 8'(FB_HEIGHT - 1)) ? y_q : y_q + 8'd1;
        end else if (accept) begin
            pack_d  = {pack_q[3:0], colour};
            phase_d = phase_q + 2'd1;
            x_d     = x_q + 8'd1;
            if (phase_q == 2'd3) begin
                push            = 1'b1;
                push_entry.addr = line_addr;
                push_entry.data = {pack_q, colour};
            end
        end

        pop        = !fifo_empty && fb_ready;
        overflow_d = overflow_q || (push && fifo_full && !pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            phase_q      <= '0;
            pack_q       <= '0;
            prev_mode_q  <= V_BLANK;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            phase_q      <= phase_d;
            pack_q       <= pack_d;
            prev_mode_q  <= prev_mode_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    fb_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign fb_wr      = !fifo_empty;
    assign fb_addr    = head.addr;
    assign fb_data    = head.data;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule
